// File: rtl/gpu_net_tx_arbiter_if.sv
// Requester-side and NI-side transmit signals of one GPU node.
// master: the arbiter's view, which drives req_ready and the NI output register.
// slave: the surrounding logic's view, which drives requests and net_ready_in.
interface gpu_net_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_lock;
    logic [16*NUM_REQ-1:0] req_flit;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           net_data_out;
    logic                  net_valid_out;
    logic                  net_ready_in;

    modport master (
        input  req_valid, req_lock, req_flit, net_ready_in,
        output req_ready, net_data_out, net_valid_out
    );

    modport slave (
        output req_valid, req_lock, req_flit, net_ready_in,
        input  req_ready, net_data_out, net_valid_out
    );
endinterface

// File: rtl/gpu_net_tx_arbiter.sv
// Round-robin arbiter sharing one 16-bit NI transmit port among NUM_REQ
// requesters. It supports locked bursts with forced rotation after MAX_BURST
// flits. Self-addressed flits are swallowed and counted.
module gpu_net_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int GPU_ID    = 10,
    parameter int MAX_BURST = 4,
    parameter int GRANT_W   = 2
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    gpu_net_tx_arbiter_if.master bus,
    output logic [GRANT_W-1:0] grant_id,
    output logic               loop_drop,
    output logic [7:0]         drop_cnt
);
    localparam logic [5:0] SELF_ID = 6'(GPU_ID);
    localparam logic [3:0] MAX_B   = 4'(MAX_BURST);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t        state_reg, state_next;
    logic [GRANT_W-1:0] lock_owner_reg, lock_owner_next;
    logic [3:0]         burst_cnt_reg, burst_cnt_next;
    logic [GRANT_W-1:0] rr_ptr_reg;
    logic [GRANT_W-1:0] grant_reg;
    logic [15:0]        net_data_reg;
    logic               net_valid_reg;
    logic               loop_drop_reg;
    logic [7:0]         drop_cnt_reg;

    logic               accept;
    logic               sel_found;
    logic [GRANT_W-1:0] sel;
    logic               hs;
    logic [15:0]        sel_flit;
    logic               sel_lock;
    logic               is_drop;

    // The output register can take a new flit when empty or draining this edge.
    assign accept   = !net_valid_reg || bus.net_ready_in;
    assign hs       = accept && sel_found;
    assign sel_flit = bus.req_flit[int'(sel)*16 +: 16];
    assign sel_lock = bus.req_lock[sel];
    assign is_drop  = (sel_flit[15:10] == SELF_ID);

    // Choose the requester to serve: the lock owner only, or round-robin after rr_ptr.
    always_comb begin
        int idx;
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        if (state_reg == LOCKED) begin
            sel       = lock_owner_reg;
            sel_found = bus.req_valid[lock_owner_reg];
        end else begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                idx = int'(rr_ptr_reg) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!sel_found && bus.req_valid[idx]) begin
                    sel_found = 1'b1;
                    sel       = GRANT_W'(idx);
                end
            end
        end
    end

    // One-hot ready to the selected requester. Ready is forced low during reset.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = ARESETn && accept && sel_found && (sel == GRANT_W'(gi));
        end
    endgenerate

    // Lock state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg      <= UNLOCKED;
            lock_owner_reg <= '0;
            burst_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            lock_owner_reg <= lock_owner_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    // Lock transitions: take the lock on a locked handshake, and drop it on the last flit, burst limit or idle unlock.
    always_comb begin
        state_next      = state_reg;
        lock_owner_next = lock_owner_reg;
        burst_cnt_next  = burst_cnt_reg;
        case (state_reg)
            UNLOCKED: begin
                // With a burst limit of one, the first flit already exhausts the lock.
                if (hs && sel_lock && (MAX_B > 4'd1)) begin
                    state_next      = LOCKED;
                    lock_owner_next = sel;
                    burst_cnt_next  = 4'd1;
                end
            end
            LOCKED: begin
                if (hs) begin
                    if (!sel_lock || (burst_cnt_reg + 4'd1 >= MAX_B)) begin
                        state_next     = UNLOCKED;
                        burst_cnt_next = 4'd0;
                    end else begin
                        burst_cnt_next = burst_cnt_reg + 4'd1;
                    end
                end else if (!bus.req_valid[lock_owner_reg] && !bus.req_lock[lock_owner_reg]) begin
                    state_next     = UNLOCKED;
                    burst_cnt_next = 4'd0;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    // Output register, rotation pointer, grant and drop accounting.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            net_data_reg  <= '0;
            net_valid_reg <= 1'b0;
            rr_ptr_reg    <= GRANT_W'(NUM_REQ - 1);
            grant_reg     <= '0;
            loop_drop_reg <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            loop_drop_reg <= hs && is_drop;
            if (hs) begin
                rr_ptr_reg <= sel;
                grant_reg  <= sel;
                if (is_drop) begin
                    // Any older flit has left this edge because accept was high.
                    net_valid_reg <= 1'b0;
                    if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end else begin
                    net_data_reg  <= sel_flit;
                    net_valid_reg <= 1'b1;
                end
            end else if (accept) begin
                net_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.net_data_out  = net_data_reg;
    assign bus.net_valid_out = net_valid_reg;
    assign grant_id          = grant_reg;
    assign loop_drop         = loop_drop_reg;
    assign drop_cnt          = drop_cnt_reg;
endmodule

// File: tb/tb_gpu_net_tx_arbiter.sv
// Directed bench for gpu_net_tx_arbiter with NUM_REQ=4, GPU_ID=10 and MAX_BURST=4.
module tb_gpu_net_tx_arbiter;
    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [1:0] grant_id;
    logic       loop_drop;
    logic [7:0] drop_cnt;
    int         total = 0;
    int         bad = 0;

    gpu_net_tx_arbiter_if #(.NUM_REQ(4)) bus();

    gpu_net_tx_arbiter #(
        .NUM_REQ(4), .GPU_ID(10), .MAX_BURST(4), .GRANT_W(2)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus.master),
        .grant_id(grant_id),
        .loop_drop(loop_drop),
        .drop_cnt(drop_cnt)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %h @%0t", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_flit(input int k, input logic [15:0] v);
        bus.req_flit[16*k +: 16] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]  valid_t [7];
        logic        lock1_t [7];
        logic [3:0]  ready_t [7];
        logic [15:0] data_t  [7];
        logic [15:0] flit1_t [7];
        int exp_k;

        ARESETn = 1'b0;
        bus.req_valid = '0;
        bus.req_lock = '0;
        bus.req_flit = '0;
        bus.net_ready_in = 1'b0;
        #12;
        // The reset state must hold while requests are already present.
        bus.req_valid = 4'b1111;
        bus.net_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) set_flit(k, 16'h2C00 | 16'(k));
        #1;
        chk("rst_valid", 32'(bus.net_valid_out), 32'd0);
        chk("rst_data", 32'(bus.net_data_out), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        ARESETn = 1'b1;

        // Full round-robin at one flit per cycle.
        for (int n = 0; n < 8; n++) begin
            exp_k = n % 4;
            #1;
            chk("rr_ready", 32'(bus.req_ready), 32'(1 << exp_k));
            tick();
            chk("rr_data", 32'(bus.net_data_out), 32'(16'h2C00 | 16'(exp_k)));
            chk("rr_valid", 32'(bus.net_valid_out), 32'd1);
            chk("rr_grant", 32'(grant_id), 32'(exp_k));
        end

        // Backpressure holds the flit and stalls every requester.
        bus.net_ready_in = 1'b0;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_valid", 32'(bus.net_valid_out), 32'd1);
            chk("bp_data", 32'(bus.net_data_out), 32'h2C03);
            tick();
        end
        bus.net_ready_in = 1'b1;
        #1;
        chk("bp_rel_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("bp_rel_data", 32'(bus.net_data_out), 32'h2C00);
        chk("bp_rel_grant", 32'(grant_id), 32'd0);

        // A self-addressed flit is swallowed and counted.
        bus.req_valid = 4'b0100;
        set_flit(2, 16'h2805);
        #1;
        chk("drop_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("drop_pulse", 32'(loop_drop), 32'd1);
        chk("drop_cnt1", 32'(drop_cnt), 32'd1);
        chk("drop_valid", 32'(bus.net_valid_out), 32'd0);
        chk("drop_grant", 32'(grant_id), 32'd2);
        bus.req_valid = 4'b0000;
        tick();
        chk("drop_pulse_end", 32'(loop_drop), 32'd0);
        chk("drop_cnt_hold", 32'(drop_cnt), 32'd1);
        chk("drop_data_kept", 32'(bus.net_data_out), 32'h2C00);
        bus.req_valid = 4'b0100;
        repeat (99) tick();
        chk("drop_cnt100", 32'(drop_cnt), 32'd100);
        repeat (200) tick();
        chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
        chk("drop_sat_valid", 32'(bus.net_valid_out), 32'd0);
        bus.req_valid = 4'b0000;
        tick();
        chk("drop_sat_hold", 32'(drop_cnt), 32'd255);

        // Locked burst by req 1 with forced rotation after four flits.
        valid_t = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010};
        lock1_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ready_t = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010};
        data_t  = '{16'h2C10, 16'h2C11, 16'h2C12, 16'h2C13, 16'h2C33, 16'h2C14, 16'h2C15};
        flit1_t = '{16'h2C10, 16'h2C11, 16'h2C12, 16'h2C13, 16'h2C14, 16'h2C14, 16'h2C15};
        set_flit(3, 16'h2C33);
        for (int c = 0; c < 7; c++) begin
            bus.req_valid = valid_t[c];
            bus.req_lock = {2'b00, lock1_t[c], 1'b0};
            set_flit(1, flit1_t[c]);
            #1;
            chk("lock_ready", 32'(bus.req_ready), 32'(ready_t[c]));
            tick();
            chk("lock_data", 32'(bus.net_data_out), 32'(data_t[c]));
            chk("lock_grant", 32'(grant_id), (ready_t[c] == 4'b1000) ? 32'd3 : 32'd1);
        end

        // An idle lock owner blocks everyone until it drops its lock.
        bus.req_valid = 4'b0001;
        bus.req_lock = 4'b0001;
        set_flit(0, 16'h2C20);
        set_flit(1, 16'h2C21);
        #1;
        chk("idle_lock_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("idle_lock_data", 32'(bus.net_data_out), 32'h2C20);
        bus.req_valid = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("idle_ready", 32'(bus.req_ready), 32'd0);
            tick();
            chk("idle_valid", 32'(bus.net_valid_out), 32'd0);
        end
        bus.req_lock = 4'b0000;
        #1;
        chk("unlock_ready", 32'(bus.req_ready), 32'd0);
        tick();
        #1;
        chk("after_ready", 32'(bus.req_ready), 32'b0010);
        tick();
        chk("after_data", 32'(bus.net_data_out), 32'h2C21);
        chk("after_grant", 32'(grant_id), 32'd1);

        // Asynchronous reset while locked and holding a flit.
        bus.req_valid = 4'b0100;
        bus.req_lock = 4'b0100;
        set_flit(2, 16'h2C02);
        #1;
        chk("pre_rst_ready", 32'(bus.req_ready), 32'b0100);
        tick();
        chk("pre_rst_data", 32'(bus.net_data_out), 32'h2C02);
        bus.net_ready_in = 1'b0;
        #2;
        ARESETn = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.net_valid_out), 32'd0);
        chk("arst_data", 32'(bus.net_data_out), 32'd0);
        chk("arst_grant", 32'(grant_id), 32'd0);
        chk("arst_pulse", 32'(loop_drop), 32'd0);
        chk("arst_cnt", 32'(drop_cnt), 32'd0);
        chk("arst_ready", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 4'b1111;
        bus.req_lock = 4'b0000;
        for (int k = 0; k < 4; k++) set_flit(k, 16'h2C00 | 16'(k));
        bus.net_ready_in = 1'b1;
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        chk("post_rst_data", 32'(bus.net_data_out), 32'h2C00);
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        chk("post_rst_valid", 32'(bus.net_valid_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpu_net_tx_arbiter.md
Name: gpu_net_tx_arbiter

Overview:
Round-robin arbiter that shares one GPU's 16-bit network-interface transmit port (net_data_out/net_valid_out/net_ready_in) among NUM_REQ on-chip requesters, such as the AXI master sequencer, the test-packet generator and the slave-side responders. Each flit is {dest_gpu[5:0], payload[9:0]}. Supports multi-flit bursts via a per-requester lock, with a forced release after MAX_BURST flits. Self-addressed flits are dropped and counted. Sits between the requesters and the NI output register of the GPU node.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GPU_ID, 10, this node's ID; flits with dest == GPU_ID are dropped
MAX_BURST, 4, maximum consecutive flits one locked requester may send before forced rotation (1..15)
GRANT_W, 2, width of grant_id, equal to clog2(NUM_REQ)

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester flit valid
req_lock  in  NUM_REQ  per-requester hold-grant request, sampled with req_valid
req_flit  in  16*NUM_REQ  flit of requester k at [16k+15:16k]
req_ready  out  NUM_REQ  per-requester accept; combinational, one-hot or zero
net_data_out  out  16  registered flit to NI
net_valid_out  out  1  registered flit valid
net_ready_in  in  1  NI accept
grant_id  out  GRANT_W  index of the last requester accepted
loop_drop  out  1  one-cycle pulse when a self-addressed flit is dropped
drop_cnt  out  8  saturating count of dropped flits

Behaviour:
- Reset values: net_data_out=0, net_valid_out=0, grant_id=0, loop_drop=0, drop_cnt=0. Internally rr_ptr=NUM_REQ-1 (so req 0 has top priority first), lock_owner=none, burst_cnt=0. req_ready=0 while reset is asserted.
- Reset asserted mid-operation: any flit held in the output register is discarded. No flit is emitted after reset.
- Output register: a flit transfers to the NI on an edge where net_valid_out && net_ready_in.
  - net_valid_out and net_data_out are held stable while net_valid_out=1 and net_ready_in=0.
- Accept window: accept = !net_valid_out || net_ready_in. This gives full throughput of 1 flit per cycle.
- Selection when accept=1 and no lock owner: pick the first k with req_valid[k], searching from rr_ptr+1 upward with wrap modulo NUM_REQ.
  - req_ready[k]=1 only for the selected k, combinational within the same cycle.
  - Handshake on edge: req_valid[k] && req_ready[k].
- On handshake, for the selected k:
  - rr_ptr <= k and grant_id <= k.
  - If req_flit[k][15:10] == GPU_ID: flit is consumed but not loaded; net_valid_out <= 0 unless an older flit is still held. loop_drop <= 1 for one cycle. drop_cnt increments, saturating at 255.
  - Otherwise: net_data_out <= flit, net_valid_out <= 1.
- Output clear: if accept=1 and nothing is handshaken, net_valid_out <= 0 after a transfer.
- Lock (two states, UNLOCKED and LOCKED):
  - UNLOCKED -> LOCKED on a handshake with req_lock[k]=1. lock_owner=k, burst_cnt=1.
  - While LOCKED, only lock_owner may receive req_ready. Other requesters wait even if the owner is idle.
  - Each further owner handshake increments burst_cnt.
  - LOCKED -> UNLOCKED when any of the following occurs:
    - an owner handshake with req_lock=0 (this flit is sent as the last of the burst);
    - an owner handshake that makes burst_cnt reach MAX_BURST;
    - an owner handshake while req_lock=1 and burst_cnt = MAX_BURST-1: the forced release is taken, and the owner must re-arbitrate.
  - Owner req_valid=0 in LOCKED: grant is held and no one is served. The owner may drop req_lock with req_valid=0, which releases the lock on the next edge.
- Dropped self-addressed flits count toward burst_cnt.
- req_flit[k] and req_lock[k] must be stable while req_valid[k]=1 and req_ready[k]=0. A requester must not drop req_valid without a handshake.

Test Plan:
- Reset, then req_valid=4'b1111 with distinct flits {dest=11, payload=k}; net_ready_in=1 -> accept order 0,1,2,3,0,…, one flit per cycle; net_data_out=16'h2C00, 16'h2C01, …
- net_ready_in=0 for 5 cycles with a flit held -> net_valid_out=1 and net_data_out stable; req_ready=0 throughout; on the first cycle net_ready_in=1, the next flit is loaded on that same edge.
- Req 2 sends a flit with dest=10 -> flit is never on net_data_out; loop_drop pulses one cycle; drop_cnt=1; 300 such drops -> drop_cnt=255.
- Req 1 holds req_lock=1 with 6 flits queued while req 3 is valid; MAX_BURST=4 -> 4 req-1 flits, then req 3, then req 1 again.
- Locked req 0 deasserts req_valid for 3 cycles while req 1 is valid -> no output for 3 cycles; req 1 served only after req 0 releases.
- Assert ARESETn low while net_valid_out=1 and LOCKED -> all outputs return to reset values asynchronously; after release, req 0 wins first when all are valid.
